// File: rtl/ex_result_stage_if.sv
// ex_result_stage_if: ALU-side input stream, writeback stream and fetch redirect of the result stage
interface ex_result_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_result;
  logic            in_flag;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic            in_we;
  logic            in_branch;
  logic            in_jal;
  logic            in_jalr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_misalign;
  modport slave (
    input  in_valid, in_result, in_flag, in_pc, in_imm, in_rd, in_we, in_branch, in_jal, in_jalr, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_we, redirect, redirect_pc, out_misalign
  );
  modport master (
    output in_valid, in_result, in_flag, in_pc, in_imm, in_rd, in_we, in_branch, in_jal, in_jalr, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_we, redirect, redirect_pc, out_misalign
  );
endinterface

// File: rtl/ex_result_stage.sv
// ex_result_stage: registers ALU results into a 2-entry skid buffer and resolves branch/jump redirects
module ex_result_stage #(
  parameter int XLEN        = 32,
  parameter bit ALIGN_CHECK = 1
) (
  input logic            clk,
  input logic            rst,
  ex_result_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } beat_t;
  state_e          state_q, state_d;
  beat_t           main_q, main_d, skid_q, skid_d, in_beat;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            redirect_q, redirect_d, misalign_q, misalign_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d, target;
  logic            wr, take, acc, keep, pop;
  always_comb begin
    wr = bus.in_we && bus.in_rd != 5'd0;
    in_beat = {(bus.in_jal || bus.in_jalr) ? bus.in_pc + XLEN'(4) : bus.in_result, wr ? bus.in_rd : 5'd0, wr};
    take = bus.in_jalr || bus.in_jal || (bus.in_branch && bus.in_flag);
    target = bus.in_jalr ? {bus.in_result[XLEN-1:1], 1'b0} : bus.in_pc + bus.in_imm;
    acc = bus.in_valid && in_ready_q;
    // a beat accepted while a redirect is on the wire is wrong-path and is dropped
    keep = acc && !redirect_q;
    pop = out_valid_q && bus.out_ready;
    redirect_d = keep && take;
    redirect_pc_d = redirect_d ? target : '0;
    misalign_d = redirect_d && ALIGN_CHECK && target[1];
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: begin
        state_d = keep ? ONE : EMPTY;
        main_d = keep ? in_beat : main_q;
      end
      ONE: begin
        state_d = (keep && !pop) ? TWO : (pop && !keep) ? EMPTY : ONE;
        main_d = (keep && pop) ? in_beat : main_q;
        skid_d = (keep && !pop) ? in_beat : skid_q;
      end
      default: begin
        state_d = pop ? ONE : TWO;
        main_d = pop ? skid_q : main_q;
      end
    endcase
    in_ready_d = state_d != TWO;
    out_valid_d = state_d != EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
    end
  end
  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = main_q.data;
  assign bus.out_rd       = main_q.rd;
  assign bus.out_we       = main_q.we;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.out_misalign = misalign_q;
endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: directed vectors, corner sequences and a queue-model random run for ex_result_stage
module tb_ex_result_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ex_result_stage_if #(.XLEN(32)) bus();
  ex_result_stage #(.XLEN(32), .ALIGN_CHECK(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] result, pc, imm;
    logic [4:0]  rd;
    logic        flag, we, br, jal, jalr;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_we, e_redir;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } wb_t;
  vec_t v[13];
  wb_t  q[$];
  function automatic vec_t mk(logic [31:0] result, pc, imm, logic [4:0] rd, logic flag, we, br, jal, jalr,
                              logic [31:0] e_data, logic [4:0] e_rd, logic e_we, e_redir, logic [31:0] e_pc, logic e_mis);
    vec_t x;
    x.result = result; x.pc = pc; x.imm = imm; x.rd = rd; x.flag = flag; x.we = we;
    x.br = br; x.jal = jal; x.jalr = jalr; x.e_data = e_data; x.e_rd = e_rd;
    x.e_we = e_we; x.e_redir = e_redir; x.e_pc = e_pc; x.e_mis = e_mis;
    return x;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(logic valid, vec_t x);
    bus.in_valid = valid; bus.in_result = x.result; bus.in_pc = x.pc; bus.in_imm = x.imm;
    bus.in_rd = x.rd; bus.in_flag = x.flag; bus.in_we = x.we; bus.in_branch = x.br;
    bus.in_jal = x.jal; bus.in_jalr = x.jalr;
  endtask
  task automatic chk_reset(string n);
    chk({n, "_in_ready"}, bus.in_ready, 1);
    chk({n, "_out_valid"}, bus.out_valid, 0);
    chk({n, "_out_data"}, bus.out_data, 0);
    chk({n, "_out_rd"}, bus.out_rd, 0);
    chk({n, "_out_we"}, bus.out_we, 0);
    chk({n, "_redirect"}, bus.redirect, 0);
    chk({n, "_redirect_pc"}, bus.redirect_pc, 0);
    chk({n, "_misalign"}, bus.out_misalign, 0);
  endtask
  function automatic vec_t alu(logic [31:0] r, logic [4:0] rd);
    return mk(r, 32'h0, 32'h0, rd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r, rd, 1'b1, 1'b0, 32'h0, 1'b0);
  endfunction
  initial begin
    vec_t a, b, c;
    logic        exp_redir, exp_mis;
    logic [31:0] exp_pc;
    v[0]  = mk(32'h7, 32'h0, 32'h0, 5'd5, 0, 1, 0, 0, 0, 32'h7, 5'd5, 1, 0, 32'h0, 0);
    v[1]  = mk(32'h1, 32'h100, 32'h20, 5'd0, 1, 0, 1, 0, 0, 32'h1, 5'd0, 0, 1, 32'h120, 0);
    v[2]  = mk(32'h0, 32'h100, 32'h20, 5'd0, 0, 0, 1, 0, 0, 32'h0, 5'd0, 0, 0, 32'h0, 0);
    v[3]  = mk(32'h333, 32'h200, 32'h0, 5'd1, 0, 1, 0, 0, 1, 32'h204, 5'd1, 1, 1, 32'h332, 1);
    v[4]  = mk(32'h336, 32'h200, 32'h0, 5'd1, 0, 1, 0, 0, 1, 32'h204, 5'd1, 1, 1, 32'h336, 1);
    v[5]  = mk(32'h339, 32'h200, 32'h0, 5'd1, 0, 1, 0, 0, 1, 32'h204, 5'd1, 1, 1, 32'h338, 0);
    v[6]  = mk(32'h5, 32'hFFFF_FFFC, 32'h8, 5'd2, 0, 1, 0, 1, 0, 32'h0, 5'd2, 1, 1, 32'h4, 0);
    v[7]  = mk(32'hAB, 32'h0, 32'h0, 5'd0, 0, 1, 0, 0, 0, 32'hAB, 5'd0, 0, 0, 32'h0, 0);
    v[8]  = mk(32'hCD, 32'h0, 32'h0, 5'd7, 0, 0, 0, 0, 0, 32'hCD, 5'd0, 0, 0, 32'h0, 0);
    v[9]  = mk(32'h800, 32'h40, 32'h100, 5'd3, 0, 1, 0, 1, 1, 32'h44, 5'd3, 1, 1, 32'h800, 0);
    v[10] = mk(32'h9, 32'h10, 32'h6, 5'd4, 0, 1, 1, 1, 0, 32'h14, 5'd4, 1, 1, 32'h16, 1);
    v[11] = mk(32'h55, 32'h300, 32'h40, 5'd6, 1, 1, 0, 0, 0, 32'h55, 5'd6, 1, 0, 32'h0, 0);
    v[12] = mk(32'h0, 32'h1000, 32'hFFFF_FFF0, 5'd0, 1, 0, 1, 0, 0, 32'h0, 5'd0, 0, 1, 32'hFF0, 0);
    drive(0, alu(0, 0));
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");
    for (int i = 0; i < 13; i++) begin
      drive(1, v[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_data", i), bus.out_data, v[i].e_data);
      chk($sformatf("v%0d_rd", i), bus.out_rd, v[i].e_rd);
      chk($sformatf("v%0d_we", i), bus.out_we, v[i].e_we);
      chk($sformatf("v%0d_redirect", i), bus.redirect, v[i].e_redir);
      if (v[i].e_redir) chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, v[i].e_pc);
      chk($sformatf("v%0d_misalign", i), bus.out_misalign, v[i].e_mis);
      @(negedge clk);
      chk($sformatf("v%0d_drain", i), bus.out_valid, 0);
      chk($sformatf("v%0d_redir_pulse", i), bus.redirect, 0);
    end
    // stalled writeback: skid fills, then drains in order
    a = alu(32'h11, 5'd1); b = alu(32'h22, 5'd2); c = alu(32'h33, 5'd3);
    bus.out_ready = 1'b0;
    drive(1, a);
    @(negedge clk);
    chk("stall_rdy1", bus.in_ready, 1);
    drive(1, b);
    @(negedge clk);
    chk("stall_rdy2", bus.in_ready, 0);
    chk("stall_head_a", bus.out_data, 32'h11);
    drive(1, c);
    @(negedge clk);
    chk("stall_rdy3", bus.in_ready, 0);
    chk("stall_hold_a", bus.out_data, 32'h11);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("drain_b_data", bus.out_data, 32'h22);
    chk("drain_b_rd", bus.out_rd, 5'd2);
    chk("drain_rdy", bus.in_ready, 1);
    @(negedge clk);
    chk("drain_empty", bus.out_valid, 0);
    // wrapping JAL followed by a wrong-path beat
    drive(1, v[6]);
    @(negedge clk);
    chk("sq_redirect", bus.redirect, 1);
    chk("sq_pc", bus.redirect_pc, 32'h4);
    chk("sq_data", bus.out_data, 32'h0);
    drive(1, alu(32'hDEAD, 5'd9));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("sq_dropped", bus.out_valid, 0);
    chk("sq_no_redir", bus.redirect, 0);
    @(negedge clk);
    chk("sq_still_empty", bus.out_valid, 0);
    // reset while full with a redirect pending
    bus.out_ready = 1'b0;
    drive(1, a);
    @(negedge clk);
    drive(1, v[6]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst_pre_full", bus.in_ready, 0);
    chk("rst_pre_redir", bus.redirect, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_reset("postrst");
    // random run against a queue model of the stage
    q.delete();
    exp_redir = 0; exp_mis = 0; exp_pc = 0;
    for (int n = 0; n < 400; n++) begin
      vec_t x;
      logic vld, acc, rdy, take;
      logic [31:0] tgt;
      int k;
      chk("rnd_valid", bus.out_valid, q.size() > 0);
      chk("rnd_in_ready", bus.in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("rnd_data", bus.out_data, q[0].data);
        chk("rnd_rd", bus.out_rd, q[0].rd);
        chk("rnd_we", bus.out_we, q[0].we);
      end
      chk("rnd_redirect", bus.redirect, exp_redir);
      if (exp_redir) chk("rnd_redirect_pc", bus.redirect_pc, exp_pc);
      chk("rnd_misalign", bus.out_misalign, exp_mis);
      k = $urandom_range(0, 9);
      x = alu($urandom, 5'($urandom));
      x.we = 1'($urandom);
      x.pc = $urandom & 32'hFFFF_FFFC;
      x.imm = $urandom_range(0, 255) - 128;
      x.flag = 1'($urandom);
      x.br = k inside {6, 7};
      x.jal = k == 8;
      x.jalr = k == 9;
      vld = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      drive(vld, x);
      bus.out_ready = rdy;
      acc = vld && q.size() < 2 && !exp_redir;
      take = x.jalr || x.jal || (x.br && x.flag);
      tgt = x.jalr ? (x.result & ~32'h1) : x.pc + x.imm;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) q.push_back('{(x.jal || x.jalr) ? x.pc + 4 : x.result,
                             (x.we && x.rd != 0) ? x.rd : 5'd0, x.we && x.rd != 0});
      exp_redir = acc && take;
      exp_pc = tgt;
      exp_mis = acc && take && tgt[1];
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
